// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit x86 core: writeback state encoding,
// ALU opcodes, register indices and ModRM field helpers.
package core_pkg;

    typedef enum logic [2:0] {
        WB_IDLE  = 3'd0,
        WB_REG   = 3'd1,
        WB_WR_LO = 3'd2,
        WB_WR_HI = 3'd3,
        WB_DONE  = 3'd4
    } wb_state_t;

    localparam logic [2:0] ALU_ADD = 3'h0;
    localparam logic [2:0] ALU_OR  = 3'h1;
    localparam logic [2:0] ALU_ADC = 3'h2;
    localparam logic [2:0] ALU_SBB = 3'h3;
    localparam logic [2:0] ALU_AND = 3'h4;
    localparam logic [2:0] ALU_SUB = 3'h5;
    localparam logic [2:0] ALU_XOR = 3'h6;
    localparam logic [2:0] ALU_CMP = 3'h7;

    localparam logic [2:0] REG_AX = 3'd0;
    localparam logic [2:0] REG_CX = 3'd1;
    localparam logic [2:0] REG_DX = 3'd2;
    localparam logic [2:0] REG_BX = 3'd3;
    localparam logic [2:0] REG_SP = 3'd4;
    localparam logic [2:0] REG_BP = 3'd5;
    localparam logic [2:0] REG_SI = 3'd6;
    localparam logic [2:0] REG_DI = 3'd7;

    localparam logic [1:0] MOD_REG = 2'b11;

    function automatic logic [1:0] modrm_mod(input logic [7:0] m);
        return m[7:6];
    endfunction

    function automatic logic [2:0] modrm_reg(input logic [7:0] m);
        return m[5:3];
    endfunction

    function automatic logic [2:0] modrm_rm(input logic [7:0] m);
        return m[2:0];
    endfunction

endpackage

// File: rtl/modrm_reg_map.sv
// Maps an operand register number and size to the 16-bit register file lane.
// Purely combinational, no latency, no backpressure.
// 8-bit numbers 4..7 are the high halves (AH..BH) of registers 0..3.
module modrm_reg_map
    import core_pkg::*;
(
    input  logic [2:0]  number,
    input  logic        size,
    input  logic [15:0] result,
    output logic [2:0]  reg_idx,
    output logic [1:0]  reg_be,
    output logic [15:0] reg_data
);

    always_comb begin
        reg_idx  = number;
        reg_be   = 2'b11;
        reg_data = result;
        if (!size) begin
            if (!number[2]) begin
                reg_be   = 2'b01;
                reg_data = {8'h00, result[7:0]};
            end else begin
                reg_idx  = {1'b0, number[1:0]};
                reg_be   = 2'b10;
                reg_data = {result[7:0], 8'h00};
            end
        end
    end

endmodule

// File: rtl/modrm_writeback.sv
// ModRM result write-back: stores an ALU result to a register or to memory over the byte bus.
// Latency: register/8-bit memory done 2 cycles after start, 16-bit memory 3 cycles.
// Backpressure: hold freezes the FSM and suppresses every strobe while high.
module modrm_writeback
    import core_pkg::*;
#(
    parameter int         AW     = 16,
    parameter logic [2:0] CMP_OP = 3'h7
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          hold,
    input  logic          start,
    input  logic [7:0]    modrm,
    input  logic          dir,
    input  logic          size,
    input  logic [2:0]    alu,
    input  logic [AW-1:0] ea,
    input  logic [15:0]   result,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] address,
    output logic [7:0]    out,
    output logic          we,
    output logic          reg_we,
    output logic [2:0]    reg_idx,
    output logic [15:0]   reg_data,
    output logic [1:0]    reg_be
);

    wb_state_t     state_q, state_d;
    logic [2:0]    number_q;
    logic          size_q;
    logic [15:0]   result_q;
    logic [AW-1:0] ea_q;

    logic [2:0]    last_idx_q;
    logic [1:0]    last_be_q;
    logic [15:0]   last_data_q;

    logic [2:0]    map_idx;
    logic [1:0]    map_be;
    logic [15:0]   map_data;

    logic          accept;
    logic          dest_is_reg;
    logic [2:0]    number_in;

    assign accept      = (state_q == WB_IDLE) && start && !hold;
    assign dest_is_reg = dir || (modrm_mod(modrm) == MOD_REG);
    assign number_in   = dir ? modrm_reg(modrm) : modrm_rm(modrm);

    modrm_reg_map u_reg_map (
        .number   (number_q),
        .size     (size_q),
        .result   (result_q),
        .reg_idx  (map_idx),
        .reg_be   (map_be),
        .reg_data (map_data)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= WB_IDLE;
            number_q    <= '0;
            size_q      <= 1'b0;
            result_q    <= '0;
            ea_q        <= '0;
            last_idx_q  <= '0;
            last_be_q   <= '0;
            last_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                number_q <= number_in;
                size_q   <= size;
                result_q <= result;
                ea_q     <= ea;
            end
            // Register outputs park on the last value actually written.
            if (reg_we) begin
                last_idx_q  <= map_idx;
                last_be_q   <= map_be;
                last_data_q <= map_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!hold) begin
            case (state_q)
                WB_IDLE: begin
                    if (start) begin
                        if (alu == CMP_OP)
                            state_d = WB_DONE;
                        else if (dest_is_reg)
                            state_d = WB_REG;
                        else
                            state_d = WB_WR_LO;
                    end
                end
                WB_REG:   state_d = WB_DONE;
                WB_WR_LO: state_d = size_q ? WB_WR_HI : WB_DONE;
                WB_WR_HI: state_d = WB_DONE;
                WB_DONE:  state_d = WB_IDLE;
                default:  state_d = WB_IDLE;
            endcase
        end
    end

    always_comb begin
        busy     = (state_q != WB_IDLE);
        done     = 1'b0;
        we       = 1'b0;
        reg_we   = 1'b0;
        out      = 8'h00;
        address  = ea_q;
        reg_idx  = last_idx_q;
        reg_be   = last_be_q;
        reg_data = last_data_q;
        case (state_q)
            WB_REG: begin
                reg_we = !hold;
                if (!hold) begin
                    reg_idx  = map_idx;
                    reg_be   = map_be;
                    reg_data = map_data;
                end
            end
            WB_WR_LO: begin
                we  = !hold;
                out = hold ? 8'h00 : result_q[7:0];
            end
            WB_WR_HI: begin
                we      = !hold;
                out     = hold ? 8'h00 : result_q[15:8];
                address = ea_q + AW'(1);
            end
            WB_DONE: done = !hold;
            default: ;
        endcase
    end

endmodule
